// File: rtl/if_scratch_reader_pkg.sv
// Shared CNN buffer definitions: reader FSM encoding and the circular
// window arithmetic used by the IF scratchpad reader.
package if_scratch_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    LOAD,
    READ,
    DONE,
    WAIT_CLR
  } rd_state_e;

  // Reduce a value into the scratchpad index range.
  function automatic logic [31:0] mod_depth(input logic [31:0] x, input logic [31:0] depth);
    return x % depth;
  endfunction

  // Inclusive length of the circular window [s, e]. Adding depth first
  // keeps the difference non-negative when the window wraps.
  function automatic logic [31:0] win_len(input logic [31:0] s, input logic [31:0] e,
                                          input logic [31:0] depth);
    return mod_depth(e + depth - s, depth) + 32'd1;
  endfunction

endpackage

// File: rtl/if_scratch_reader_if.sv
// Handshake bundle between the IF window writer/PE side and the reader.
interface if_scratch_reader_if #(
  parameter int ADDR_LEN = 4,
  parameter int FILT_W   = 4
);
  logic                start;
  logic                IF_end_valid;
  logic [ADDR_LEN-1:0] start_IF;
  logic [ADDR_LEN-1:0] end_IF;
  logic [FILT_W-1:0]   filt_len;
  logic [FILT_W-1:0]   stride;
  logic                pe_ready;
  logic [ADDR_LEN-1:0] IF_raddr;
  logic                IF_ren;
  logic                win_first;
  logic                win_last;
  logic                full_done;

  modport master (
    output start, IF_end_valid, start_IF, end_IF, filt_len, stride, pe_ready,
    input  IF_raddr, IF_ren, win_first, win_last, full_done
  );

  modport slave (
    input  start, IF_end_valid, start_IF, end_IF, filt_len, stride, pe_ready,
    output IF_raddr, IF_ren, win_first, win_last, full_done
  );
endinterface

// File: rtl/if_scratch_reader_raddr_gen.sv
// Window registers, position/element counters and read address arithmetic.
// Next-state values are exported so the FSM can register its window flags
// one cycle ahead of the reads they describe.
module if_raddr_gen
  import if_scratch_reader_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int FILT_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic                adv,
  input  logic [ADDR_LEN-1:0] start_IF,
  input  logic [ADDR_LEN-1:0] end_IF,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [FILT_W-1:0]   stride,
  output logic [ADDR_LEN-1:0] addr,
  output logic                in_range,
  output logic                in_range_nxt,
  output logic                first_nxt,
  output logic                last_nxt
);
  localparam int CW = FILT_W + ADDR_LEN;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [ADDR_LEN-1:0] s0, s0_nxt;
  logic [ADDR_LEN:0]   len, len_nxt;
  logic [FILT_W-1:0]   k, k_nxt;
  logic [FILT_W-1:0]   seff, seff_nxt;
  logic [CW-1:0]       p, p_nxt;
  logic [CW-1:0]       i, i_nxt;
  logic [ADDR_LEN:0]   sum;

  // A filter position is readable only if all K taps lie inside the window.
  function automatic logic fits(input logic [CW-1:0] pos, input logic [FILT_W-1:0] klen,
                                input logic [ADDR_LEN:0] wlen);
    return (klen != '0) && ((pos + CW'(klen) - ONE) < CW'(wlen));
  endfunction

  // Next values: restart clears counters, LOAD captures the window, accepted reads step i then p.
  always_comb begin
    s0_nxt   = s0;
    len_nxt  = len;
    k_nxt    = k;
    seff_nxt = seff;
    p_nxt    = p;
    i_nxt    = i;
    if (clr) begin
      p_nxt = '0;
      i_nxt = '0;
    end else if (load) begin
      s0_nxt   = start_IF;
      len_nxt  = (ADDR_LEN+1)'(win_len(32'(start_IF), 32'(end_IF), 32'(SCRATCH_DEPTH)));
      k_nxt    = filt_len;
      seff_nxt = (stride == '0) ? FILT_W'(1) : stride;
      p_nxt    = '0;
      i_nxt    = '0;
    end else if (adv) begin
      if (i == CW'(k) - ONE) begin
        i_nxt = '0;
        p_nxt = p + CW'(seff);
      end else begin
        i_nxt = i + ONE;
      end
    end
  end

  // Window and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0   <= '0;
      len  <= '0;
      k    <= '0;
      seff <= '0;
      p    <= '0;
      i    <= '0;
    end else begin
      s0   <= s0_nxt;
      len  <= len_nxt;
      k    <= k_nxt;
      seff <= seff_nxt;
      p    <= p_nxt;
      i    <= i_nxt;
    end
  end

  assign in_range     = fits(p, k, len);
  assign in_range_nxt = fits(p_nxt, k_nxt, len_nxt);
  assign first_nxt    = (i_nxt == '0);
  assign last_nxt     = (i_nxt == CW'(k_nxt) - ONE);

  // p+i stays below the window length while reading, so ADDR_LEN+1 bits hold S0+p+i.
  assign sum  = (ADDR_LEN+1)'(p + i) + {1'b0, s0};
  assign addr = ADDR_LEN'(mod_depth(32'(sum), 32'(SCRATCH_DEPTH)));

endmodule

// File: rtl/if_scratch_reader.sv
// IF scratchpad reader: walks a closed circular window filter position by
// filter position and signals the writer once the window is consumed.
module if_scratch_reader
  import if_scratch_reader_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int FILT_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  if_scratch_reader_if.slave  bus
);
  rd_state_e           state;
  logic                win_first_q;
  logic                win_last_q;
  logic                full_done_q;
  logic [ADDR_LEN-1:0] addr;
  logic                in_range;
  logic                in_range_nxt;
  logic                first_nxt;
  logic                last_nxt;
  logic                load;
  logic                ren;
  logic                adv;

  assign load = (state == LOAD);
  assign ren  = (state == READ) && in_range;
  assign adv  = ren && bus.pe_ready;

  if_raddr_gen #(
    .ADDR_LEN      (ADDR_LEN),
    .SCRATCH_DEPTH (SCRATCH_DEPTH),
    .FILT_W        (FILT_W)
  ) u_raddr_gen (
    .clk          (clk),
    .rst          (rst),
    .clr          (bus.start),
    .load         (load),
    .adv          (adv),
    .start_IF     (bus.start_IF),
    .end_IF       (bus.end_IF),
    .filt_len     (bus.filt_len),
    .stride       (bus.stride),
    .addr         (addr),
    .in_range     (in_range),
    .in_range_nxt (in_range_nxt),
    .first_nxt    (first_nxt),
    .last_nxt     (last_nxt)
  );

  // Reader FSM; window flags are registered from the counters' next values so they line up with IF_ren.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      win_first_q <= 1'b0;
      win_last_q  <= 1'b0;
      full_done_q <= 1'b0;
    end else begin
      win_first_q <= 1'b0;
      win_last_q  <= 1'b0;
      full_done_q <= 1'b0;
      if (bus.start) begin
        state <= WAIT_WIN;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          WAIT_WIN: if (bus.IF_end_valid) state <= LOAD;
          LOAD: begin
            state       <= READ;
            win_first_q <= in_range_nxt && first_nxt;
            win_last_q  <= in_range_nxt && last_nxt;
          end
          READ: begin
            if (!in_range) begin
              state       <= DONE;
              full_done_q <= 1'b1;
            end else begin
              win_first_q <= in_range_nxt && first_nxt;
              win_last_q  <= in_range_nxt && last_nxt;
            end
          end
          DONE: state <= WAIT_CLR;
          WAIT_CLR: if (!bus.IF_end_valid) state <= WAIT_WIN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.IF_ren    = ren;
  assign bus.IF_raddr  = ren ? addr : '0;
  assign bus.win_first = win_first_q;
  assign bus.win_last  = win_last_q;
  assign bus.full_done = full_done_q;

endmodule

// File: tb/tb_if_scratch_reader.sv
// Directed bench for if_scratch_reader with hand-computed read sequences.
module tb_if_scratch_reader;
  localparam int ADDR_LEN      = 4;
  localparam int SCRATCH_DEPTH = 16;
  localparam int FILT_W        = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_scratch_reader_if #(.ADDR_LEN(ADDR_LEN), .FILT_W(FILT_W)) bus ();

  if_scratch_reader #(
    .ADDR_LEN      (ADDR_LEN),
    .SCRATCH_DEPTH (SCRATCH_DEPTH),
    .FILT_W        (FILT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int rd_addr[$];
  int rd_first[$];
  int rd_last[$];
  int first_ren_cyc;
  int done_cyc;
  int done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  // Present one window and log every accepted read. Optional stall of
  // stall_len cycles at read index stall_at (raddr must stay at exp_stall),
  // optional abort (0: rst, 1: start) once abort_at reads have been taken.
  task automatic run_win(input string tag, input int s, input int e, input int k, input int st,
                         input int stall_at, input int stall_len, input int exp_stall,
                         input int abort_at, input int abort_kind);
    int stall_left;
    rd_addr.delete();
    rd_first.delete();
    rd_last.delete();
    first_ren_cyc = -1;
    done_cyc      = -1;
    done_cnt      = 0;
    stall_left    = stall_len;
    @(posedge clk); #1;
    bus.start_IF     = ADDR_LEN'(s);
    bus.end_IF       = ADDR_LEN'(e);
    bus.filt_len     = FILT_W'(k);
    bus.stride       = FILT_W'(st);
    bus.pe_ready     = 1'b1;
    bus.IF_end_valid = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (bus.full_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.IF_ren && first_ren_cyc < 0) first_ren_cyc = cyc;
      // IF_end_valid stays high for 4 cycles past the pulse
      if (done_cyc >= 0 && cyc == done_cyc + 4) break;
      if (bus.IF_ren && rd_addr.size() == abort_at) begin
        if (abort_kind == 0) begin
          rst = 1'b1;
          bus.IF_end_valid = 1'b0;
          #1;
          check({tag, "_rst_ctl"}, 32'({bus.IF_ren, bus.win_first, bus.win_last, bus.full_done}), 32'd0);
          check({tag, "_rst_addr"}, 32'(bus.IF_raddr), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          pulse_start();
        end else begin
          bus.start = 1'b1;
          bus.IF_end_valid = 1'b0;
          @(posedge clk); #1 bus.start = 1'b0;
          @(negedge clk);
          check({tag, "_start_ctl"}, 32'({bus.IF_ren, bus.win_first, bus.win_last, bus.full_done}), 32'd0);
          check({tag, "_start_addr"}, 32'(bus.IF_raddr), 32'd0);
        end
        check({tag, "_abort_no_done"}, 32'(done_cnt), 32'd0);
        return;
      end
      bus.pe_ready = 1'b1;
      if (bus.IF_ren && rd_addr.size() == stall_at && stall_left > 0) begin
        bus.pe_ready = 1'b0;
        stall_left--;
        check({tag, "_stall_raddr"}, 32'(bus.IF_raddr), 32'(exp_stall));
      end
      if (bus.IF_ren && bus.pe_ready) begin
        rd_addr.push_back(int'(bus.IF_raddr));
        rd_first.push_back(int'(bus.win_first));
        rd_last.push_back(int'(bus.win_last));
      end
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    @(posedge clk); #1 bus.IF_end_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic compare_reads(input string tag, input int exp[$], input int k);
    check({tag, "_count"}, 32'(rd_addr.size()), 32'(exp.size()));
    for (int j = 0; j < exp.size() && j < rd_addr.size(); j++) begin
      check($sformatf("%s_addr%0d", tag, j), 32'(rd_addr[j]), 32'(exp[j]));
      check($sformatf("%s_first%0d", tag, j), 32'(rd_first[j]), 32'((j % k) == 0));
      check($sformatf("%s_last%0d", tag, j), 32'(rd_last[j]), 32'((j % k) == (k - 1)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp[$];
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.IF_end_valid = 1'b0;
    bus.start_IF     = '0;
    bus.end_IF       = '0;
    bus.filt_len     = '0;
    bus.stride       = '0;
    bus.pe_ready     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ren",   32'(bus.IF_ren),    32'd0);
    check("rst_raddr", 32'(bus.IF_raddr),  32'd0);
    check("rst_first", 32'(bus.win_first), 32'd0);
    check("rst_last",  32'(bus.win_last),  32'd0);
    check("rst_done",  32'(bus.full_done), 32'd0);
    rst = 1'b0;
    pulse_start();

    // L=8, K=3, S=1: positions 0..5, addresses p+i
    run_win("A", 0, 7, 3, 1, -1, 0, 0, -1, 0);
    exp.delete();
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 3; i++) exp.push_back(p + i);
    compare_reads("A", exp, 3);
    check("A_latency",  32'(first_ren_cyc), 32'd2);
    check("A_done_cyc", 32'(done_cyc),      32'd21);

    // wrapped window 14..3: L=6, K=3, S=2 -> positions 0 and 2, (14+p+i) mod 16
    run_win("B", 14, 3, 3, 2, -1, 0, 0, -1, 0);
    exp = '{14, 15, 0, 0, 1, 2};
    compare_reads("B", exp, 3);
    check("B_latency",  32'(first_ren_cyc), 32'd2);
    check("B_done_cyc", 32'(done_cyc),      32'd9);

    // K=3 exceeds L=2: no reads, LOAD at cycle 1 so done at cycle 3
    run_win("C", 5, 6, 3, 1, -1, 0, 0, -1, 0);
    exp.delete();
    compare_reads("C", exp, 3);
    check("C_done_cyc", 32'(done_cyc), 32'd3);

    // K=0: nothing to read
    run_win("K0", 0, 7, 0, 1, -1, 0, 0, -1, 0);
    check("K0_count",    32'(rd_addr.size()), 32'd0);
    check("K0_done_cyc", 32'(done_cyc),       32'd3);

    // L=5, K=3, stride 0 acts as 1; stall 3 cycles on read 1 (i=1, addr 1)
    run_win("D", 0, 4, 3, 0, 1, 3, 1, -1, 0);
    exp = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
    compare_reads("D", exp, 3);
    check("D_done_cyc", 32'(done_cyc), 32'd15);

    // K=1: every read is both first and last
    run_win("E", 10, 12, 1, 1, -1, 0, 0, -1, 0);
    exp = '{10, 11, 12};
    compare_reads("E", exp, 1);

    // reset mid-READ, then a fresh window 2..6 (L=5, K=2, S=1)
    run_win("F", 0, 7, 3, 1, -1, 0, 0, 4, 0);
    run_win("F2", 2, 6, 2, 1, -1, 0, 0, -1, 0);
    exp = '{2, 3, 3, 4, 4, 5, 5, 6};
    compare_reads("F2", exp, 2);

    // start mid-READ, then window 8..15 (L=8, K=3, S=3) from its first address
    run_win("G", 8, 15, 3, 3, -1, 0, 0, 2, 1);
    run_win("G2", 8, 15, 3, 3, -1, 0, 0, -1, 0);
    exp = '{8, 9, 10, 11, 12, 13};
    compare_reads("G2", exp, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
